// File: rtl/mem_cycle_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_cycle_pkg;

    localparam int MEM_XLEN   = 64;
    localparam int BYTE_LANES = MEM_XLEN / 8;

    // Load/store size codes as carried in funct3.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } funct3_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Byte-lane mask for an access of the given size (funct3[1:0]) at byte offset off.
    function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [1:0] size,
                                                        input logic [2:0] off);
        logic [BYTE_LANES-1:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return (size == 2'b11) ? base : (base << off);
    endfunction

    // An access is misaligned when its offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off[1:0] != 2'b00;
            default: return off != 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/memory_cycle_load_align.sv
// Load alignment: moves the addressed bytes down to bit 0 and extends them.
module load_align_unit #(
    parameter int XLEN        = 64,
    parameter int FUNCT3_SIZE = 3
) (
    input  logic [XLEN-1:0]        rdata,
    input  logic [2:0]             off,
    input  logic [FUNCT3_SIZE-1:0] funct3,
    output logic [XLEN-1:0]        data
);
    import mem_cycle_pkg::*;

    logic [XLEN-1:0] shifted;

    // Shift the addressed lane to the bottom, then sign- or zero-extend by size.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        shifted = rdata >> {off, 3'b000};
        data    = shifted;
        case (funct3_e'(funct3))
            LB:      data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            LH:      data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LW:      data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            LBU:     data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            LHU:     data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            LWU:     data = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// Memory-access stage: one load/store per instruction over a req/ack data port,
// with a registered one-cycle writeback pulse per instruction.
module memory_cycle #(
    parameter int XLEN          = 64,
    parameter int FUNCT3_SIZE   = 3,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [XLEN-1:0]          ex_alu_result,
    input  logic [XLEN-1:0]          ex_store_data,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic [FUNCT3_SIZE-1:0]   ex_funct3,
    input  logic [REG_ADDR_SIZE-1:0] ex_rd,
    input  logic                     ex_reg_write,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [XLEN-1:0]          dmem_addr,
    output logic [XLEN-1:0]          dmem_wdata,
    output logic [XLEN/8-1:0]        dmem_be,
    input  logic                     dmem_ack,
    input  logic [XLEN-1:0]          dmem_rdata,
    output logic                     wb_valid,
    output logic [XLEN-1:0]          wb_data,
    output logic [REG_ADDR_SIZE-1:0] wb_rd,
    output logic                     wb_reg_write,
    output logic                     mem_err
);
    import mem_cycle_pkg::*;

    state_e state_q, state_d;

    logic       accept;
    logic       is_mem;
    logic       access_err;
    logic       start_mem;
    logic       retire;
    logic [2:0] off;

    logic [XLEN-1:0]          cap_addr;
    logic [FUNCT3_SIZE-1:0]   cap_funct3;
    logic [REG_ADDR_SIZE-1:0] cap_rd;
    logic                     cap_reg_write;
    logic                     cap_load;
    logic [XLEN-1:0]          load_data;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign off      = ex_alu_result[2:0];
    assign is_mem   = ex_mem_read || ex_mem_write;

    // Errors retire immediately without touching memory.
    assign access_err = is_mem && ((ex_mem_read && ex_mem_write)
                                || (ex_mem_write && ex_funct3[2])
                                || (ex_mem_read && (&ex_funct3))
                                || is_misaligned(ex_funct3[1:0], off));

    assign start_mem = accept && is_mem && !access_err;
    // dmem_ack only counts while a request is outstanding.
    assign retire    = (state_q == BUSY) && dmem_ack;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: enter BUSY for a legal memory op, leave on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mem) state_d = BUSY;
            BUSY:    if (dmem_ack)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the accepted memory op for use when the ack arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_addr      <= '0;
            cap_funct3    <= '0;
            cap_rd        <= '0;
            cap_reg_write <= 1'b0;
            cap_load      <= 1'b0;
        end else if (start_mem) begin
            cap_addr      <= ex_alu_result;
            cap_funct3    <= ex_funct3;
            cap_rd        <= ex_rd;
            cap_reg_write <= ex_reg_write;
            cap_load      <= ex_mem_read;
        end
    end

    // Memory request: launched on accept, held stable until ack; reset abandons it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else if (start_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= {ex_alu_result[XLEN-1:3], 3'b000};
            dmem_wdata <= ex_store_data << {off, 3'b000};
            dmem_be    <= lane_mask(ex_funct3[1:0], off);
        end else if (retire) begin
            dmem_req   <= 1'b0;
        end
    end

    load_align_unit #(
        .XLEN        (XLEN),
        .FUNCT3_SIZE (FUNCT3_SIZE)
    ) u_load_align (
        .rdata  (dmem_rdata),
        .off    (cap_addr[2:0]),
        .funct3 (cap_funct3),
        .data   (load_data)
    );

    // Writeback: one pulse per instruction, from the ack or straight from accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_err      <= 1'b0;
            if (retire) begin
                wb_valid     <= 1'b1;
                wb_rd        <= cap_rd;
                wb_data      <= cap_load ? load_data : cap_addr;
                wb_reg_write <= cap_load && cap_reg_write;
            end else if (accept && !start_mem) begin
                wb_valid     <= 1'b1;
                wb_rd        <= ex_rd;
                wb_data      <= ex_alu_result;
                wb_reg_write <= ex_reg_write && !access_err;
                mem_err      <= access_err;
            end
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: a transaction-level model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_memory_cycle;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        ex_valid      = 1'b0;
    logic [63:0] ex_alu_result = '0;
    logic [63:0] ex_store_data = '0;
    logic        ex_mem_read   = 1'b0;
    logic        ex_mem_write  = 1'b0;
    logic [2:0]  ex_funct3     = '0;
    logic [4:0]  ex_rd         = '0;
    logic        ex_reg_write  = 1'b0;
    logic        dmem_ack      = 1'b0;
    logic [63:0] dmem_rdata    = '0;

    logic        ex_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_err;

    int   vectors     = 0;
    int   miscompares = 0;
    logic cmp_en      = 1'b0;

    localparam logic [63:0] IDLE_RDATA = 64'hA5A5_5A5A_A5A5_5A5A;

    always #5 clk = ~clk;

    memory_cycle dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .mem_err       (mem_err)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic       mem;
        logic       err;
        logic       load;
        logic [7:0] be;
        logic [63:0] wdata;
    } dec_t;

    function automatic dec_t decode(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [63:0] addr, input logic [63:0] sd);
        dec_t d;
        int size;
        int off;
        size   = 1 << f3[1:0];
        off    = int'(addr % 64'd8);
        d.mem  = rd || wr;
        d.load = rd && !wr;
        d.err  = d.mem && ((rd && wr) || (wr && f3 > 3'd3) || (rd && f3 == 3'd7) || (off % size != 0));
        d.be    = '0;
        d.wdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= off && i < off + size) d.be[i] = 1'b1;
            if (i >= off) d.wdata[8*i +: 8] = sd[8*(i-off) +: 8];
        end
        return d;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] rdata, input logic [2:0] f3, input int off);
        logic [63:0] v;
        int size;
        size = 1 << f3[1:0];
        v    = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!f3[2] && size < 8 && v[8*size-1])
            for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    logic        m_busy = 1'b0;
    logic        e_req = 1'b0, e_we = 1'b0, e_wb_valid = 1'b0, e_wb_rw = 1'b0, e_err = 1'b0;
    logic [63:0] e_addr = '0, e_wdata = '0, e_wb_data = '0;
    logic [7:0]  e_be = '0;
    logic [4:0]  e_wb_rd = '0;
    logic        p_load = 1'b0, p_rw = 1'b0;
    logic [63:0] p_addr = '0;
    logic [2:0]  p_f3 = '0;
    logic [4:0]  p_rd = '0;
    int          p_off = 0;

    always @(posedge clk or posedge reset) begin
        dec_t d;
        if (reset) begin
            m_busy = 1'b0; e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
            e_wb_valid = 1'b0; e_wb_data = '0; e_wb_rd = '0; e_wb_rw = 1'b0; e_err = 1'b0;
        end else begin
            e_wb_valid = 1'b0;
            e_err      = 1'b0;
            if (m_busy) begin
                if (dmem_ack) begin
                    m_busy     = 1'b0;
                    e_req      = 1'b0;
                    e_wb_valid = 1'b1;
                    e_wb_rd    = p_rd;
                    e_wb_rw    = p_load && p_rw;
                    e_wb_data  = p_load ? extend(dmem_rdata, p_f3, p_off) : p_addr;
                end
            end else if (ex_valid) begin
                d = decode(ex_mem_read, ex_mem_write, ex_funct3, ex_alu_result, ex_store_data);
                if (!d.mem) begin
                    e_wb_valid = 1'b1; e_wb_data = ex_alu_result; e_wb_rd = ex_rd; e_wb_rw = ex_reg_write;
                end else if (d.err) begin
                    e_wb_valid = 1'b1; e_wb_rd = ex_rd; e_wb_rw = 1'b0; e_err = 1'b1;
                end else begin
                    m_busy  = 1'b1;
                    e_req   = 1'b1;
                    e_we    = ex_mem_write;
                    e_addr  = ex_alu_result - (ex_alu_result % 64'd8);
                    e_wdata = d.wdata;
                    e_be    = d.be;
                    p_load  = d.load; p_rw = ex_reg_write; p_addr = ex_alu_result;
                    p_f3    = ex_funct3; p_rd = ex_rd; p_off = int'(ex_alu_result % 64'd8);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ex_ready", {63'd0, ex_ready}, {63'd0, !m_busy});
            check("dmem_req", {63'd0, dmem_req}, {63'd0, e_req});
            if (e_req) begin
                check("dmem_we",    {63'd0, dmem_we}, {63'd0, e_we});
                check("dmem_addr",  dmem_addr, e_addr);
                check("dmem_be",    {56'd0, dmem_be}, {56'd0, e_be});
                if (e_we) check("dmem_wdata", dmem_wdata, e_wdata);
            end
            check("wb_valid", {63'd0, wb_valid}, {63'd0, e_wb_valid});
            check("mem_err",  {63'd0, mem_err},  {63'd0, e_err});
            if (e_wb_valid) begin
                check("wb_rd",        {59'd0, wb_rd}, {59'd0, e_wb_rd});
                check("wb_reg_write", {63'd0, wb_reg_write}, {63'd0, e_wb_rw});
                if (!e_err) check("wb_data", wb_data, e_wb_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] alu,
                         input logic [63:0] sd, input logic [4:0] rdi, input logic rw);
        ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3; ex_alu_result = alu;
        ex_store_data = sd; ex_rd = rdi; ex_reg_write = rw;
    endtask

    // Issue one memory op, ack it after 'waits' extra cycles, and report what was observed.
    task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] alu,
                          input logic [63:0] sd, input logic [4:0] rdi, input logic rw,
                          input int waits, input logic [63:0] rdata,
                          output int req_cnt, output int busy_cnt, output int lat,
                          output logic [63:0] first_addr, output logic [63:0] first_wdata,
                          output logic [7:0] first_be, output logic first_we,
                          output logic [63:0] wbd, output logic wbrw);
        drive(rd, wr, f3, alu, sd, rdi, rw);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid    = 1'b0;
        first_addr  = dmem_addr;
        first_wdata = dmem_wdata;
        first_be    = dmem_be;
        first_we    = dmem_we;
        req_cnt = 0; busy_cnt = 0; lat = 0;
        for (int c = 0; c <= waits; c++) begin
            if (dmem_req)  req_cnt++;
            if (!ex_ready) busy_cnt++;
            if (c == waits) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
            @(posedge clk); #1;
            lat++;
            dmem_ack   = 1'b0;
            dmem_rdata = IDLE_RDATA;
        end
        while (!wb_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        wbd  = wb_data;
        wbrw = wb_reg_write;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [63:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sd;
        logic [7:0]  be;
        logic [63:0] wdata;
    } st_vec_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic        err;
    } er_vec_t;

    ld_vec_t ld_tbl[6] = '{
        '{3'b001, 64'h5006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001},
        '{3'b101, 64'h5006, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001},
        '{3'b010, 64'h5004, 64'hF000_0000_1234_5678, 64'hFFFF_FFFF_F000_0000},
        '{3'b110, 64'h5004, 64'hF000_0000_1234_5678, 64'h0000_0000_F000_0000},
        '{3'b000, 64'h5001, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F},
        '{3'b011, 64'h5008, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001}
    };

    st_vec_t st_tbl[3] = '{
        '{3'b000, 64'h7005, 64'h1122_3344_5566_77AB, 8'h20, 64'h6677_AB00_0000_0000},
        '{3'b010, 64'h7004, 64'h0000_0000_CAFE_F00D, 8'hF0, 64'hCAFE_F00D_0000_0000},
        '{3'b011, 64'h7008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF}
    };

    er_vec_t er_tbl[7] = '{
        '{1'b0, 1'b0, 3'b000, 64'hAAAA, 1'b0},
        '{1'b0, 1'b1, 3'b100, 64'h8000, 1'b1},
        '{1'b1, 1'b0, 3'b001, 64'h8001, 1'b1},
        '{1'b1, 1'b1, 3'b011, 64'h8000, 1'b1},
        '{1'b1, 1'b0, 3'b111, 64'h8000, 1'b1},
        '{1'b0, 1'b1, 3'b011, 64'h8004, 1'b1},
        '{1'b0, 1'b0, 3'b000, 64'hBBBB, 1'b0}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int          rc, bc, lat;
        logic [63:0] fa, fw, wbd;
        logic [7:0]  fb;
        logic        fwe, wbrw;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst dmem_req",     {63'd0, dmem_req}, 64'd0);
        check("rst dmem_we",      {63'd0, dmem_we}, 64'd0);
        check("rst dmem_addr",    dmem_addr, 64'd0);
        check("rst dmem_wdata",   dmem_wdata, 64'd0);
        check("rst dmem_be",      {56'd0, dmem_be}, 64'd0);
        check("rst wb_valid",     {63'd0, wb_valid}, 64'd0);
        check("rst wb_data",      wb_data, 64'd0);
        check("rst wb_rd",        {59'd0, wb_rd}, 64'd0);
        check("rst wb_reg_write", {63'd0, wb_reg_write}, 64'd0);
        check("rst mem_err",      {63'd0, mem_err}, 64'd0);
        check("rst ex_ready",     {63'd0, ex_ready}, 64'd1);
        reset  = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // Non-memory op retires next cycle
        drive(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("alu wb_valid",     {63'd0, wb_valid}, 64'd1);
        check("alu wb_data",      wb_data, 64'h1234);
        check("alu wb_rd",        {59'd0, wb_rd}, 64'd5);
        check("alu wb_reg_write", {63'd0, wb_reg_write}, 64'd1);
        check("alu dmem_req",     {63'd0, dmem_req}, 64'd0);

        // LB / LBU at 0x1003, ack in the first request cycle
        mem_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd10, 1'b1, 0, 64'h0000_0000_8000_0000,
               rc, bc, lat, fa, fw, fb, fwe, wbd, wbrw);
        check("lb dmem_addr", fa, 64'h1000);
        check("lb dmem_be",   {56'd0, fb}, 64'h08);
        check("lb req cycles", 64'(rc), 64'd1);
        check("lb latency",   64'(lat), 64'd1);
        check("lb wb_data",   wbd, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op(1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 5'd10, 1'b1, 0, 64'h0000_0000_8000_0000,
               rc, bc, lat, fa, fw, fb, fwe, wbd, wbrw);
        check("lbu wb_data",  wbd, 64'h80);

        // SH at 0x2006
        mem_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 5'd3, 1'b1, 1, 64'h0,
               rc, bc, lat, fa, fw, fb, fwe, wbd, wbrw);
        check("sh dmem_we",    {63'd0, fwe}, 64'd1);
        check("sh dmem_be",    {56'd0, fb}, 64'hC0);
        check("sh dmem_wdata", fw, 64'hBEEF_0000_0000_0000);
        check("sh wb_reg_write", {63'd0, wbrw}, 64'd0);
        check("sh wb_data",    wbd, 64'h2006);
        check("sh latency",    64'(lat), 64'd2);

        // Misaligned LW at 0x3002
        drive(1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 5'd4, 1'b1);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("lw-mis mem_err",      {63'd0, mem_err}, 64'd1);
        check("lw-mis wb_valid",     {63'd0, wb_valid}, 64'd1);
        check("lw-mis wb_reg_write", {63'd0, wb_reg_write}, 64'd0);
        check("lw-mis dmem_req",     {63'd0, dmem_req}, 64'd0);
        check("lw-mis ex_ready",     {63'd0, ex_ready}, 64'd1);
        @(posedge clk); #1;
        check("lw-mis pulse end",    {63'd0, mem_err}, 64'd0);

        // LD with three wait cycles, then an immediate follow-on op
        mem_op(1'b1, 1'b0, 3'b011, 64'h4008, 64'h0, 5'd12, 1'b1, 3, 64'h0123_4567_89AB_CDEF,
               rc, bc, lat, fa, fw, fb, fwe, wbd, wbrw);
        check("ld req cycles",  64'(rc), 64'd4);
        check("ld busy cycles", 64'(bc), 64'd4);
        check("ld latency",     64'(lat), 64'd4);
        check("ld dmem_addr",   fa, 64'h4008);
        check("ld dmem_be",     {56'd0, fb}, 64'hFF);
        check("ld wb_data",     wbd, 64'h0123_4567_89AB_CDEF);
        check("ld ready after", {63'd0, ex_ready}, 64'd1);
        drive(1'b0, 1'b0, 3'b000, 64'h5555, 64'h0, 5'd1, 1'b1);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("follow wb_data", wb_data, 64'h5555);

        // Load extension table
        foreach (ld_tbl[i]) begin
            mem_op(1'b1, 1'b0, ld_tbl[i].f3, ld_tbl[i].addr, 64'h0, 5'(i + 16), 1'b1, i % 3,
                   ld_tbl[i].rdata, rc, bc, lat, fa, fw, fb, fwe, wbd, wbrw);
            check("ld-tbl wb_data", wbd, ld_tbl[i].exp);
        end

        // Store lane table
        foreach (st_tbl[i]) begin
            mem_op(1'b0, 1'b1, st_tbl[i].f3, st_tbl[i].addr, st_tbl[i].sd, 5'(i + 24), 1'b1, i,
                   64'h0, rc, bc, lat, fa, fw, fb, fwe, wbd, wbrw);
            check("st-tbl dmem_be",    {56'd0, fb}, {56'd0, st_tbl[i].be});
            check("st-tbl dmem_wdata", fw, st_tbl[i].wdata);
            check("st-tbl wb_data",    wbd, st_tbl[i].addr);
        end

        // Back-to-back non-memory and error ops, one per cycle
        foreach (er_tbl[i]) begin
            drive(er_tbl[i].rd, er_tbl[i].wr, er_tbl[i].f3, er_tbl[i].addr, 64'h0, 5'(i + 1), 1'b1);
            ex_valid = 1'b1;
            @(posedge clk); #1;
            check("b2b wb_valid", {63'd0, wb_valid}, 64'd1);
            check("b2b mem_err",  {63'd0, mem_err}, {63'd0, er_tbl[i].err});
            check("b2b dmem_req", {63'd0, dmem_req}, 64'd0);
        end
        ex_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while BUSY, then a stray ack
        drive(1'b1, 1'b0, 3'b010, 64'h6000, 64'h0, 5'd7, 1'b1);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("busy dmem_req", {63'd0, dmem_req}, 64'd1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("rst-busy dmem_req", {63'd0, dmem_req}, 64'd0);
        check("rst-busy ex_ready", {63'd0, ex_ready}, 64'd1);
        @(posedge clk); #1;
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = IDLE_RDATA;
        check("late-ack wb_valid", {63'd0, wb_valid}, 64'd0);
        check("late-ack dmem_req", {63'd0, dmem_req}, 64'd0);
        check("late-ack ex_ready", {63'd0, ex_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("late-ack quiet", {63'd0, wb_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
